// File: rtl/stopwatch_display_driver_if.sv
// Digit/pause inputs from the stopwatch counter and 7-segment drive outputs.
interface stopwatch_display_driver_if;
  logic [3:0] msb_bcd;
  logic [3:0] lsb_bcd;
  logic       paused;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  modport master (output msb_bcd, lsb_bcd, paused, input seg, an, frame_tick);
  modport slave  (input msb_bcd, lsb_bcd, paused, output seg, an, frame_tick);
endinterface

// File: rtl/stopwatch_display_driver.sv
// Two-digit multiplexed 7-segment driver: per-frame digit snapshot, blink while
// paused, leading-zero blanking and a dash for non-BCD digit values.
module stopwatch_display_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 250,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  stopwatch_display_driver_if.slave  bus
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef struct packed {
    logic [3:0] msb;
    logic [3:0] lsb;
    logic       paused;
  } in_t;

  in_t           in_q, in_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          sel_q, sel_d;
  logic [3:0]    snap_msb_q, snap_msb_d;
  logic [3:0]    snap_lsb_q, snap_lsb_d;
  logic          snap_vld_q, snap_vld_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          frame_tick_q, frame_tick_d;

  logic       tick, frame_end, blank;
  logic [3:0] digit;
  logic [6:0] seg_hi;
  logic [1:0] an_hi;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b1000000;
    endcase
  endfunction

  always_comb begin
    in_d         = '{msb: bus.msb_bcd, lsb: bus.lsb_bcd, paused: bus.paused};
    tick         = (ref_cnt_q == REF_LAST);
    frame_end    = tick && sel_q;
    ref_cnt_d    = tick ? '0 : ref_cnt_q + 1'b1;
    sel_d        = sel_q ^ tick;
    frame_tick_d = frame_end;

    snap_msb_d = snap_msb_q;
    snap_lsb_d = snap_lsb_q;
    snap_vld_d = snap_vld_q;
    if (frame_end) begin
      snap_msb_d = in_q.msb;
      snap_lsb_d = in_q.lsb;
      snap_vld_d = 1'b1;
    end

    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!in_q.paused) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (frame_end) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Nothing is shown until the first snapshot exists, so reset never flashes "0".
    digit  = sel_q ? snap_lsb_q : snap_msb_q;
    blank  = !snap_vld_q || !blink_on_q || (!sel_q && BLANK_LZ && (snap_msb_q == 4'd0));
    seg_hi = blank ? 7'b0 : seg7(digit);
    an_hi  = blank ? 2'b00 : (sel_q ? 2'b01 : 2'b10);
    seg_d  = ACTIVE_LOW ? ~seg_hi : seg_hi;
    an_d   = ACTIVE_LOW ? ~an_hi : an_hi;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q         <= '0;
      ref_cnt_q    <= '0;
      sel_q        <= 1'b0;
      snap_msb_q   <= '0;
      snap_lsb_q   <= '0;
      snap_vld_q   <= 1'b0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      in_q         <= in_d;
      ref_cnt_q    <= ref_cnt_d;
      sel_q        <= sel_d;
      snap_msb_q   <= snap_msb_d;
      snap_lsb_q   <= snap_lsb_d;
      snap_vld_q   <= snap_vld_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Bench for the stopwatch display driver: two instances (leading-zero blanking on/off)
// compared every cycle against a frame/slot arithmetic model.
module tb_stopwatch_display_driver;
  localparam int DIV = 4;
  localparam int BF  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stopwatch_display_driver_if b1 ();
  stopwatch_display_driver_if b0 ();

  stopwatch_display_driver #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1))
    dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  stopwatch_display_driver #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0))
    dut0 (.clk(clk), .reset(reset), .bus(b0.slave));

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16];

  // model state: edges since reset, registered inputs, snapshot, paused-frame count
  int         n;
  logic [3:0] q_msb, q_lsb, s_msb, s_lsb, cur_msb, cur_lsb;
  logic       q_p, cur_p, s_vld;
  int         pf;
  logic [6:0] e_seg1, e_seg0;
  logic [1:0] e_an1, e_an0;
  logic       e_ft;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic apply(input logic [3:0] m, input logic [3:0] l, input logic p);
    cur_msb = m; cur_lsb = l; cur_p = p;
    b1.msb_bcd = m; b1.lsb_bcd = l; b1.paused = p;
    b0.msb_bcd = m; b0.lsb_bcd = l; b0.paused = p;
  endtask

  task automatic model_reset();
    n = 0; q_msb = 0; q_lsb = 0; q_p = 0; s_msb = 0; s_lsb = 0; s_vld = 0; pf = 0;
  endtask

  task automatic expect_disp(input bit lz, input int sel, output logic [6:0] s, output logic [1:0] a);
    bit vis;
    vis = s_vld && ((pf / BF) % 2 == 0) && !(sel == 0 && lz && s_msb == 4'd0);
    if (vis) begin
      s = ~seg_tab[(sel == 1) ? s_lsb : s_msb];
      a = (sel == 1) ? 2'b10 : 2'b01;
    end else begin
      s = 7'h7f;
      a = 2'b11;
    end
  endtask

  task automatic check_off(input string tag);
    chk({tag, "_seg1"}, {1'b0, b1.seg}, 8'h7f);
    chk({tag, "_an1"},  {6'b0, b1.an},  8'h03);
    chk({tag, "_ft1"},  {7'b0, b1.frame_tick}, 8'h00);
    chk({tag, "_seg0"}, {1'b0, b0.seg}, 8'h7f);
    chk({tag, "_an0"},  {6'b0, b0.an},  8'h03);
  endtask

  task automatic step();
    bit fe;
    @(posedge clk);
    n++;
    // display after edge n reflects slot/snapshot/blink state after edge n-1
    expect_disp(1'b1, ((n - 1) / DIV) % 2, e_seg1, e_an1);
    expect_disp(1'b0, ((n - 1) / DIV) % 2, e_seg0, e_an0);
    fe   = (n % (2 * DIV)) == 0;
    e_ft = fe;
    if (!q_p) pf = 0;
    else if (fe) pf++;
    if (fe) begin
      s_msb = q_msb; s_lsb = q_lsb; s_vld = 1'b1;
    end
    q_msb = cur_msb; q_lsb = cur_lsb; q_p = cur_p;
    @(negedge clk);
    chk("seg_lz1", {1'b0, b1.seg}, {1'b0, e_seg1});
    chk("an_lz1",  {6'b0, b1.an},  {6'b0, e_an1});
    chk("ft_lz1",  {7'b0, b1.frame_tick}, {7'b0, e_ft});
    chk("seg_lz0", {1'b0, b0.seg}, {1'b0, e_seg0});
    chk("an_lz0",  {6'b0, b0.an},  {6'b0, e_an0});
    chk("ft_lz0",  {7'b0, b0.frame_tick}, {7'b0, e_ft});
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
                7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                7'b1000000};
    reset = 1'b1;
    apply(4'd5, 4'd7, 1'b0);
    model_reset();
    #1;
    check_off("reset");
    @(negedge clk);
    reset = 1'b0;

    // first frame dark, then 5 / 7 alternating
    run(24);
    // leading zero
    apply(4'd0, 4'd3, 1'b0);
    run(24);
    // non-BCD digits -> dash
    apply(4'd12, 4'd15, 1'b0);
    run(16);
    // mid-frame change must wait for the next frame end
    apply(4'd5, 4'd7, 1'b0);
    run(18);
    apply(4'd5, 4'd8, 1'b0);
    run(20);
    // pause: normal 2 frames, dark 2, normal 2
    apply(4'd5, 4'd8, 1'b1);
    run(56);
    for (int i = 0; i < 40; i++) begin
      if ((pf / BF) % 2 == 1) break;
      step();
    end
    chk("reached_dark", {7'b0, ((pf / BF) % 2 == 1)}, 8'h01);
    run(3);
    apply(4'd5, 4'd8, 1'b0);
    run(8);
    // asynchronous reset in the middle of a frame
    run(5);
    reset = 1'b1;
    #1;
    check_off("midreset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    apply(4'd5, 4'd7, 1'b0);
    run(24);

    // randomized digits and pause episodes
    for (int i = 0; i < 500; i++) begin
      logic [3:0] m, l;
      logic p;
      m = cur_msb; l = cur_lsb; p = cur_p;
      if ($urandom_range(0, 7) == 0) begin
        m = 4'($urandom_range(0, 15));
        l = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 59) == 0) p = ~p;
      apply(m, l, p);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
